// File: rtl/fft_spi_frame.sv
// SPI frame engine: serial load, parallel handoff to the FFT core, serial unload.
// Optional loopback path enabled by FFT_SPI_LOOPBACK_EN.
module fft_spi_frame #(
  parameter int SAMPLES = 64,
  parameter int WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sck,
  input  logic                       sdi,
  output logic                       sdo,
  output logic                       done,
  output logic [SAMPLES*WIDTH-1:0]   frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  input  logic [SAMPLES*WIDTH-1:0]   result_data,
  input  logic                       result_valid
`ifdef FFT_SPI_LOOPBACK_EN
  ,
  input  logic                       loopback
`endif
);

  localparam int FB = SAMPLES * WIDTH;
  localparam int CW = $clog2(FB + 1);
  localparam logic [CW-1:0] LAST = CW'(FB - 1);

  typedef enum logic [1:0] {
    LOAD,
    HANDOFF,
    WAIT_RESULT,
    UNLOAD
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    sck_sync;
  logic [1:0]    sdi_sync;
  logic          rise, fall;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [FB-1:0] in_reg, in_nxt;
  logic [FB-1:0] out_reg, out_nxt;
  logic          lb_q;

  assign rise = sck_sync[1] & ~sck_sync[2];
  assign fall = ~sck_sync[1] & sck_sync[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      state    <= LOAD;
      cnt      <= '0;
      in_reg   <= '0;
      out_reg  <= '0;
    end else begin
      sck_sync <= {sck_sync[1:0], sck};
      sdi_sync <= {sdi_sync[0], sdi};
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      in_reg   <= in_nxt;
      out_reg  <= out_nxt;
    end
  end

`ifdef FFT_SPI_LOOPBACK_EN
  // loopback only matters as sampled on the way into HANDOFF
  always_ff @(posedge clk) begin
    if (reset)
      lb_q <= 1'b0;
    else if (state == LOAD && state_nxt == HANDOFF)
      lb_q <= loopback;
  end
`else
  assign lb_q = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_nxt    = in_reg;
    out_nxt   = out_reg;
    unique case (state)
      LOAD: begin
        if (rise) begin
          in_nxt = {in_reg[FB-2:0], sdi_sync[1]};
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = HANDOFF;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      HANDOFF: begin
        if (lb_q) begin
          out_nxt   = in_reg;
          state_nxt = UNLOAD;
        end else if (frame_ready) begin
          state_nxt = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (result_valid) begin
          out_nxt   = result_data;
          state_nxt = UNLOAD;
        end
      end
      UNLOAD: begin
        if (fall) begin
          out_nxt = {out_reg[FB-2:0], 1'b0};
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign frame_data  = in_reg;
  assign frame_valid = (state == HANDOFF) & ~lb_q;
  assign done        = (state == UNLOAD);
  assign sdo         = done & out_reg[FB-1];

endmodule

// File: doc/fft_spi_frame.md
# fft_spi_frame

Parametrised SPI frame engine between the external microcontroller SPI link and the FFT core. Serially loads a frame of SAMPLES words of WIDTH bits, hands it to the core as one parallel word with a valid/ready handshake, captures the core's result frame, and shifts it back out on sdo. It generalises the fixed 64×16-bit SPI load/unload path to any depth and width, adds a core handshake and an optional loopback path.

## Interface
- SAMPLES, default 64: words per frame, ≥2.
- WIDTH, default 16: bits per word, ≥2.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; returns block to LOAD.
- sck  in  1  SPI clock from master, asynchronous to clk.
- sdi  in  1  SPI data in, asynchronous to clk.
- sdo  out  1  SPI data out.
- done  out  1  result frame ready for readout.
- frame_data  out  SAMPLES*WIDTH  loaded frame; word 0 in the top WIDTH bits.
- frame_valid  out  1  frame_data valid toward core.
- frame_ready  in  1  core accepts frame.
- result_data  in  SAMPLES*WIDTH  core output; word 0 in the top WIDTH bits.
- result_valid  in  1  result_data valid; one-cycle pulse or level.
- loopback  in  1  present only with FFT_SPI_LOOPBACK_EN; see Configuration.

## Operation
- sck and sdi each pass through a 2-flop synchroniser, then one more register for edge detection. Rising/falling edges are detected from the synchronised sck.
- FRAME_BITS = SAMPLES*WIDTH. Bit counter width is $clog2(FRAME_BITS+1).
- Bit order: word 0 first, MSB first. The first bit received lands in frame_data[FRAME_BITS-1].
- States:
  - LOAD: on each sck rising edge, shift synchronised sdi into the LSB of the input register and increment the counter. When the counter reaches FRAME_BITS, clear the counter and go to HANDOFF.
  - HANDOFF: frame_valid=1 and frame_data stable. When frame_valid&&frame_ready, go to WAIT_RESULT.
  - WAIT_RESULT: on result_valid, copy result_data into the output register and go to UNLOAD.
  - UNLOAD: done=1 and sdo = output register MSB. On each sck falling edge, shift the output register left and increment the counter. After the falling edge that completes bit FRAME_BITS, clear the counter, drop done and go to LOAD.
- sck edges in HANDOFF and WAIT_RESULT are ignored; the counter and registers are unchanged.
- result_valid outside WAIT_RESULT is ignored.
- frame_ready outside HANDOFF is ignored.
- Reset values: state LOAD, counter 0, input and output registers 0, sdo 0, done 0, frame_valid 0.
- Reset mid-frame in any state discards all partial data. The next frame starts at bit 0.
- Master protocol: drive sdi before raising sck. In UNLOAD, sample sdo on the sck rising edge.

## Timing
- Edge-detection latency: 3 clk cycles from an sck pin edge to the internal action.
- sck high and low times must each be ≥4 clk cycles.
- sdi must be stable from 1 clk before the sck rising edge until 4 clk after it.
- frame_valid rises on the clk cycle after the action for the last loaded bit.
- frame_valid falls on the cycle after the handshake. Combinational frame_ready in the same cycle is allowed.
- done and sdo (output MSB) are valid the cycle after the result_valid capture.
- After each detected falling edge, sdo updates in the same clk cycle as the shift. The next bit is therefore valid ≥1 sck-low time before the next rising edge.
- done drops the clk cycle after the final shift.
- The first LOAD edge is accepted on the cycle after entering LOAD.

## Configuration
- FFT_SPI_LOOPBACK_EN defined: adds the loopback port.
  - With loopback=1 at the HANDOFF entry, the block does not assert frame_valid.
  - It copies the input register into the output register and enters UNLOAD on the next cycle, so the echoed frame equals the sent frame.
  - loopback is sampled only at HANDOFF entry.
- Not defined: the port is absent and the loopback path does not exist.

## Test plan
- Reset check: assert reset 4 cycles mid-LOAD after 100 bits, then shift a full frame → frame_valid asserts only after FRAME_BITS new bits. All outputs are 0 during reset.
- SAMPLES=4, WIDTH=8: shift 0x12_34_56_78 with frame_ready held 1 → frame_data=0x12345678 and frame_valid high for exactly 1 cycle. Then drive result_data=0xA1B2C3D4 with a result_valid pulse → done=1 and sdo reads back 0xA1B2C3D4 MSB first. done=0 after bit 32.
- Default 64×16, 64 square-wave words (0x7FFF ×32, 0x8001 ×32):
  - Hold frame_ready=0 for 50 cycles → frame_valid stays high and frame_data is stable.
  - Then a handshake followed by a result produces a 1024-bit readout matching result_data.
- 20 sck pulses during WAIT_RESULT → ignored; readout is still exact. result_valid asserted in LOAD → no state change.
- Back-to-back frames: a second frame immediately after unload completes → correct data. The counter does not carry over.
- With FFT_SPI_LOOPBACK_EN and loopback=1: send 0xDEADBEEF (4×8) → frame_valid never asserts and sdo returns 0xDEADBEEF.
